// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified instruction/data memory port: arbiter
// states and the funct3 access-size codes used by the memory and LSU logic.
package mem_port_arbiter_pkg;

    // Arbiter FSM state encodings
    localparam logic [2:0] ARB_IDLE   = 3'd0;
    localparam logic [2:0] ARB_BUSY_I = 3'd1;
    localparam logic [2:0] ARB_BUSY_D = 3'd2;
    localparam logic [2:0] ARB_ACK_I  = 3'd3;
    localparam logic [2:0] ARB_ACK_D  = 3'd4;

    // funct3 load/store size codes
    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    // IDLE and both ACK states are the cycles in which a new access may be issued.
    function automatic logic is_arb_state(input logic [2:0] s);
        return (s == ARB_IDLE) || (s == ARB_ACK_I) || (s == ARB_ACK_D);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between the IF stage and
// the MEM stage. Data requests win over fetches; each access occupies the
// memory for MEM_LAT cycles and completes with a one-cycle ack pulse.
//
// Handshake: a requester raises its request (if_req, or d_rd/d_wr) with
// stable address/data and holds it until it sees its ack for one cycle;
// read data is valid in the ack cycle and is held until the next completion
// on that port. Requests are only sampled in arbitration cycles (IDLE,
// ACK_I, ACK_D); in an ACK cycle the port just served is ignored.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_size,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_size,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]        mem_size_q, mem_size_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;

    logic d_go;
    logic i_go;

    // Eligible requesters this cycle, with the just-acked port masked out
    always_comb begin
        d_go = (d_rd | d_wr) & (state_q != ARB_ACK_D);
        i_go = if_req & (state_q != ARB_ACK_I);
    end

    // Next-state logic: arbitration, issue, latency countdown and completion
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;

        if (is_arb_state(state_q)) begin
            if (d_go) begin
                // d_rd and d_wr together resolve to a store
                state_d     = ARB_BUSY_D;
                cnt_d       = CNT_INIT;
                mem_en_d    = 1'b1;
                mem_we_d    = d_wr;
                mem_addr_d  = d_addr;
                mem_wdata_d = d_wdata;
                mem_size_d  = d_size;
            end else if (i_go) begin
                state_d     = ARB_BUSY_I;
                cnt_d       = CNT_INIT;
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b0;
                mem_addr_d  = if_addr;
                mem_wdata_d = d_wdata;
                mem_size_d  = SIZE_W;
            end else begin
                state_d  = ARB_IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        end else if ((state_q == ARB_BUSY_I) || (state_q == ARB_BUSY_D)) begin
            if (cnt_q == '0) begin
                mem_we_d = 1'b0;
                // mem_en stays up through the ACK cycle when the other port is
                // waiting: it is held until acked, so it wins that cycle's
                // arbitration and the enable is continuous across the handover.
                if (state_q == ARB_BUSY_I) begin
                    if_rdata_d = mem_rdata;
                    if_ack_d   = 1'b1;
                    state_d    = ARB_ACK_I;
                    mem_en_d   = d_rd | d_wr;
                end else begin
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_ack_d  = 1'b1;
                    state_d  = ARB_ACK_D;
                    mem_en_d = if_req;
                end
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else begin
            state_d  = ARB_IDLE;
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
        end
    end

    // State and output registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    // Output mapping and pipeline stall generation
    always_comb begin
        mem_en    = mem_en_q;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        mem_size  = mem_size_q;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
        if_ack    = if_ack_q;
        d_ack     = d_ack_q;
        stall_if  = if_req & ~if_ack_q;
        stall_mem = (d_rd | d_wr) & ~d_ack_q;
        dbg_state = state_q;
    end

endmodule
